// File: rtl/conv_pkg.sv
// Shared constants and state type for the convolution frame driver.
package conv_pkg;
  localparam int IFM_DIM = 14;
  localparam int IFM_LEN = IFM_DIM * IFM_DIM;  // 196 IFM words
  localparam int W_LEN   = 9;                  // 3x3 kernel
  localparam int OFM_LEN = 36;                 // 6x6 pooled results
  localparam int W_BASE  = IFM_LEN;            // weights follow the IFM in cfg space
  localparam int DATA_W  = 16;
  localparam int RES_W   = 36;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_RECV
  } drv_state_e;
endpackage

// File: rtl/conv_result_capture.sv
// Result buffer, capture counter, idle/timeout counter and registered read port.
module conv_result_capture #(
  parameter int TIMEOUT_CYC = 512,
  parameter int RES_W       = conv_pkg::RES_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,       // start accepted: restart the result count
  input  logic             cap_en,    // driver is in WAIT or RECV
  input  logic             out_valid,
  input  logic [RES_W-1:0] out_ofm,
  input  logic [5:0]       rd_addr,
  output logic [RES_W-1:0] rd_data,
  output logic             last_cap,  // this cycle captures the final result
  output logic             expire     // idle counter hits the limit this cycle
);
  import conv_pkg::*;

  localparam int                IDLE_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

  logic [RES_W-1:0]  res_q [OFM_LEN];
  logic [5:0]        cnt_q, cnt_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [RES_W-1:0]  rd_data_q, rd_data_d;
  logic              cap;

  // Next-state for counters, frame-end detection and read mux.
  always_comb begin
    cap    = cap_en & out_valid;
    cnt_d  = cnt_q;
    idle_d = idle_q;
    if (clr) begin
      cnt_d  = '0;
      idle_d = '0;
    end else if (cap) begin
      cnt_d  = cnt_q + 6'd1;
      idle_d = '0;
    end else if (cap_en) begin
      idle_d = idle_q + 1'b1;
    end else begin
      idle_d = '0;
    end
    last_cap  = cap && (cnt_q == 6'(OFM_LEN - 1));
    expire    = cap_en && !cap && (idle_q == IDLE_LAST);
    rd_data_d = '0;
    if (rd_addr < 6'(OFM_LEN)) rd_data_d = res_q[rd_addr];
  end

  // Counters, buffer writes and the registered read port (reads see pre-write data).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idle_q    <= '0;
      rd_data_q <= '0;
      for (int i = 0; i < OFM_LEN; i++) res_q[i] <= '0;
    end else begin
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
      rd_data_q <= rd_data_d;
      if (cap && (cnt_q < 6'(OFM_LEN))) res_q[cnt_q] <= out_ofm;
    end
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/conv_frame_driver.sv
// Host-side frame driver: buffers one IFM frame and kernel, streams them to
// the conv/pool engine and captures the pooled results.
module conv_frame_driver #(
  parameter int TIMEOUT_CYC = 512,
  parameter int DATA_W      = conv_pkg::DATA_W,
  parameter int RES_W       = conv_pkg::RES_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [7:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              overflow,
  output logic              cfg_err,
  output logic              in_valid,
  output logic [DATA_W-1:0] In_IFM,
  output logic [DATA_W-1:0] In_Weight,
  input  logic              out_valid,
  input  logic [RES_W-1:0]  Out_OFM,
  input  logic [5:0]        rd_addr,
  output logic [RES_W-1:0]  rd_data
);
  import conv_pkg::*;

  drv_state_e        state_q, state_d;
  logic [DATA_W-1:0] ifm_q [IFM_LEN];
  logic [DATA_W-1:0] w_q   [W_LEN];
  logic [7:0]        beat_q, beat_d;      // index of the next beat to drive
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              overflow_q, overflow_d;
  logic              cfg_err_q, cfg_err_d;
  logic              in_valid_q, in_valid_d;
  logic [DATA_W-1:0] in_ifm_q, in_ifm_d;
  logic [DATA_W-1:0] in_w_q, in_w_d;
  logic              start_acc, cfg_ok, cap_en, last_cap, expire;
  logic [7:0]        w_idx;

  // FSM next-state, stream generation and status flags.
  always_comb begin
    start_acc  = (state_q == ST_IDLE) && start;
    cfg_ok     = cfg_we && (state_q == ST_IDLE) && !start;
    cap_en     = (state_q == ST_WAIT) || (state_q == ST_RECV);
    w_idx      = cfg_addr - 8'(W_BASE);
    state_d    = state_q;
    beat_d     = beat_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    timeout_d  = timeout_q;
    overflow_d = overflow_q;
    cfg_err_d  = cfg_we && !cfg_ok;
    in_valid_d = 1'b0;
    in_ifm_d   = '0;
    in_w_d     = '0;
    // Results arriving while we are not listening are dropped and flagged.
    if (out_valid && !cap_en) overflow_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SEND;
          busy_d     = 1'b1;
          timeout_d  = 1'b0;
          overflow_d = 1'b0;  // start wins over a same-cycle stray out_valid
          in_valid_d = 1'b1;
          in_ifm_d   = ifm_q[0];
          in_w_d     = w_q[0];
          beat_d     = 8'd1;
        end
      end
      ST_SEND: begin
        if (beat_q < 8'(IFM_LEN)) begin
          in_valid_d = 1'b1;
          in_ifm_d   = ifm_q[beat_q];
          if (beat_q < 8'(W_LEN)) in_w_d = w_q[beat_q[3:0]];
          beat_d     = beat_q + 8'd1;
        end else begin
          state_d = ST_WAIT;
          beat_d  = '0;
        end
      end
      ST_WAIT, ST_RECV: begin
        if (last_cap || expire) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          timeout_d = timeout_q | expire;
        end else if ((state_q == ST_WAIT) && out_valid) begin
          state_d = ST_RECV;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register FSM state and all driven outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      in_valid_q <= 1'b0;
      in_ifm_q   <= '0;
      in_w_q     <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
      cfg_err_q  <= cfg_err_d;
      in_valid_q <= in_valid_d;
      in_ifm_q   <= in_ifm_d;
      in_w_q     <= in_w_d;
    end
  end

  // Config write port into the IFM and weight buffers; 205..255 fall through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IFM_LEN; i++) ifm_q[i] <= '0;
      for (int i = 0; i < W_LEN; i++)   w_q[i]   <= '0;
    end else if (cfg_ok) begin
      if (cfg_addr < 8'(IFM_LEN))              ifm_q[cfg_addr]   <= cfg_data;
      else if (cfg_addr < 8'(W_BASE + W_LEN))  w_q[w_idx[3:0]]   <= cfg_data;
    end
  end

  conv_result_capture #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .RES_W       (RES_W)
  ) u_cap (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start_acc),
    .cap_en    (cap_en),
    .out_valid (out_valid),
    .out_ofm   (Out_OFM),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .last_cap  (last_cap),
    .expire    (expire)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign overflow  = overflow_q;
  assign cfg_err   = cfg_err_q;
  assign in_valid  = in_valid_q;
  assign In_IFM    = in_ifm_q;
  assign In_Weight = in_w_q;
endmodule

// File: tb/tb_conv_frame_driver.sv
// Directed + randomized bench for conv_frame_driver with a behavioural engine stub.
module tb_conv_frame_driver;
  localparam int T = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        start = 1'b0;
  logic        busy, done, timeout, overflow, cfg_err, in_valid;
  logic [15:0] In_IFM, In_Weight;
  logic        out_valid = 1'b0;
  logic [35:0] Out_OFM = '0;
  logic [5:0]  rd_addr = '0;
  logic [35:0] rd_data;

  always #5 clk = ~clk;

  conv_frame_driver #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .busy(busy), .done(done), .timeout(timeout), .overflow(overflow),
    .cfg_err(cfg_err), .in_valid(in_valid), .In_IFM(In_IFM), .In_Weight(In_Weight),
    .out_valid(out_valid), .Out_OFM(Out_OFM), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  int n_chk = 0, n_fail = 0, done_cnt = 0;
  logic [15:0] sq_ifm[$], sq_w[$];
  logic [15:0] ifm_m [196];
  logic [15:0] w_m   [9];
  logic [35:0] resp  [36];
  logic [35:0] res_m [36];
  logic first_err, first_ovf, first_busy, mid_err;
  logic pre_done, post_done, after_done;

  // Stream recorder and done-pulse counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (in_valid) begin
      sq_ifm.push_back(In_IFM);
      sq_w.push_back(In_Weight);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // 3x3 valid convolution then 2x2 max-pool, result j = pooled (j/6, j%6).
  function automatic logic [35:0] conv_pool(input int j);
    logic [35:0] best, s;
    best = '0;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++) begin
        s = '0;
        for (int kr = 0; kr < 3; kr++)
          for (int kc = 0; kc < 3; kc++)
            s += 36'(ifm_m[(2*(j/6)+dr+kr)*14 + 2*(j%6)+dc+kc]) * 36'(w_m[kr*3+kc]);
        if (s > best) best = s;
      end
    return best;
  endfunction

  function automatic int stream_errs();
    int e = 0;
    if (sq_ifm.size() != 196) return 999;
    for (int k = 0; k < 196; k++) begin
      if (sq_ifm[k] !== ifm_m[k]) e++;
      if (sq_w[k] !== ((k < 9) ? w_m[k] : 16'd0)) e++;
    end
    return e;
  endfunction

  task automatic cfg_write(input int a, input int d);
    cfg_addr = 8'(a); cfg_data = 16'(d); cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic rd(input int a, output logic [35:0] d);
    rd_addr = 6'(a);
    @(negedge clk);
    d = rd_data;
  endtask

  // Launch a frame; optional same-cycle cfg_we / out_valid and a mid-stream write.
  task automatic send_frame(input bit sim_we, input bit sim_ov, input bit mid_we, output int n);
    sq_ifm.delete(); sq_w.delete();
    start = 1'b1;
    if (sim_we) begin cfg_we = 1'b1; cfg_addr = 8'd0; cfg_data = 16'hBEEF; end
    if (sim_ov) begin out_valid = 1'b1; Out_OFM = 36'hDEAD; end
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0; out_valid = 1'b0;
    first_err = cfg_err; first_ovf = overflow; first_busy = busy;
    n = 0;
    for (int i = 0; i < 600; i++) begin
      if (!in_valid) break;
      n++;
      if (n == 51) mid_err = cfg_err;
      cfg_we = mid_we && (n == 50);
      cfg_addr = 8'd1; cfg_data = 16'hBEEF;
      @(negedge clk);
    end
    cfg_we = 1'b0;
  endtask

  // Engine stub: return resp[0..35] with random 0..gapmax idle cycles between beats.
  task automatic respond(input int gapmax);
    for (int j = 0; j < 36; j++) begin
      repeat ($urandom_range(0, gapmax)) @(negedge clk);
      out_valid = 1'b1; Out_OFM = resp[j];
      if (j == 35) pre_done = done;
      @(negedge clk);
      out_valid = 1'b0;
      res_m[j] = resp[j];
    end
    post_done = done;
    @(negedge clk);
    after_done = done;
  endtask

  task automatic check_res(input string tag);
    logic [35:0] d;
    for (int j = 0; j < 36; j++) begin
      rd(j, d);
      chk($sformatf("%s_res%0d", tag, j), d, res_m[j]);
    end
  endtask

  initial begin
    int n, c, d0;
    logic [35:0] d;
    for (int i = 0; i < 196; i++) ifm_m[i] = '0;
    for (int k = 0; k < 9; k++) w_m[k] = '0;
    for (int j = 0; j < 36; j++) res_m[j] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_outs", {busy, done, timeout, overflow, cfg_err, in_valid, In_IFM, In_Weight}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rd", rd_data, 0);
    rd(0, d); chk("rst_res0", d, 0);

    // T1: ramp IFM, unit kernel, engine-model results
    for (int i = 0; i < 196; i++) begin cfg_write(i, i); ifm_m[i] = 16'(i); end
    for (int k = 0; k < 9; k++) begin cfg_write(196 + k, 1); w_m[k] = 16'd1; end
    chk("t1_cfg_ok", cfg_err, 0);
    cfg_write(230, 16'h5555);
    chk("t1_ign_noerr", cfg_err, 0);
    for (int j = 0; j < 36; j++) resp[j] = conv_pool(j);
    d0 = done_cnt;
    send_frame(0, 0, 0, n);
    chk("t1_busy", first_busy, 1);
    chk("t1_beats", n, 196);
    chk("t1_stream", stream_errs(), 0);
    respond(0);
    chk("t1_pre_done", pre_done, 0);
    chk("t1_done", post_done, 1);
    chk("t1_done_1cyc", after_done, 0);
    chk("t1_done_cnt", done_cnt - d0, 1);
    chk("t1_timeout", timeout, 0);
    chk("t1_busy_end", busy, 0);
    rd(0, d);  chk("t1_r0", d, 270);
    rd(35, d); chk("t1_r35", d, 1620);
    check_res("t1");

    // T2: no response -> timeout exactly T cycles after the last beat
    d0 = done_cnt;
    send_frame(0, 0, 0, n);
    chk("t2_beats", n, 196);
    c = 0;
    for (int i = 0; i < T + 100; i++) begin
      @(negedge clk);
      c++;
      if (done) break;
    end
    chk("t2_latency", c, T);
    chk("t2_timeout", timeout, 1);
    chk("t2_busy", busy, 0);
    @(negedge clk);
    chk("t2_done_1cyc", done, 0);
    chk("t2_done_cnt", done_cnt - d0, 1);
    check_res("t2");

    // T3: gapped responses 1000+j, out-of-range reads
    for (int j = 0; j < 36; j++) resp[j] = 36'(1000 + j);
    send_frame(0, 0, 0, n);
    chk("t3_timeout_clr", timeout, 0);
    respond(3);
    chk("t3_pre_done", pre_done, 0);
    chk("t3_done", post_done, 1);
    check_res("t3");
    rd(36, d); chk("t3_rd36", d, 0);
    rd(63, d); chk("t3_rd63", d, 0);

    // T4: dropped writes (with start, during SEND), then re-stream unchanged buffers
    send_frame(1, 0, 1, n);
    chk("t4_err_start", first_err, 1);
    chk("t4_err_send", mid_err, 1);
    chk("t4_streamA", stream_errs(), 0);
    for (int j = 0; j < 36; j++) resp[j] = {4'h0, $urandom()};
    respond(0);
    send_frame(0, 0, 0, n);
    chk("t4_streamB", stream_errs(), 0);
    for (int j = 0; j < 36; j++) resp[j] = {$urandom_range(0, 15), $urandom()};
    respond(2);
    check_res("t4");

    // T5: stray out_valid after done -> overflow; start+out_valid clears it
    d0 = done_cnt;
    out_valid = 1'b1; Out_OFM = 36'hDEAD;
    @(negedge clk);
    out_valid = 1'b0;
    chk("t5_overflow", overflow, 1);
    chk("t5_no_done", done_cnt - d0, 0);
    rd(0, d); chk("t5_res0", d, res_m[0]);
    send_frame(0, 1, 0, n);
    chk("t5_ovf_clr", first_ovf, 0);
    chk("t5_busy", first_busy, 1);
    for (int j = 0; j < 36; j++) resp[j] = 36'(j * 7 + 3);
    respond(1);
    chk("t5_ovf_end", overflow, 0);
    check_res("t5");

    // T6: reset at beat ~100, then a frame streams the cleared buffers
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    chk("t6_mid_valid", in_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", in_valid, 0);
    chk("t6_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_no_done", done_cnt - d0, 0);
    for (int i = 0; i < 196; i++) ifm_m[i] = '0;
    for (int k = 0; k < 9; k++) w_m[k] = '0;
    for (int j = 0; j < 36; j++) res_m[j] = '0;
    rd(5, d); chk("t6_res_clr", d, 0);
    send_frame(0, 0, 0, n);
    chk("t6_beats", n, 196);
    chk("t6_stream_zero", stream_errs(), 0);
    for (int j = 0; j < 36; j++) resp[j] = {4'h0, $urandom()};
    respond(2);
    chk("t6_done", post_done, 1);
    check_res("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
